// File: rtl/ex_stage_pkg.sv
// Shared constants for the execute stage: ALU control codes and ALUOp encodings.
package ex_stage_pkg;

  localparam int XLEN_DEFAULT       = 64;
  localparam int REG_ADDR_W_DEFAULT = 5;

  // 4-bit ALU control codes understood by the ALU
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011
  } alu_ctrl_e;

  // ALUOp field produced by the main decoder
  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } alu_op_e;

  // funct3 values the decoder distinguishes
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_OR     = 3'b110;

endpackage

// File: rtl/alu.sv
// 64-bit ALU: add/sub/and/or with zero flag and signed overflow status.
module alu
  import ex_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      Alu_control,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            overflow
);

  // Operation select; overflow is signed and only meaningful for add/sub
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (Alu_control)
      ALU_ADD: begin
        result   = a + b;
        overflow = (a[XLEN-1] == b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
      end
      ALU_SUB: begin
        result   = a - b;
        overflow = (a[XLEN-1] != b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_stage_alu_control.sv
// Decodes ALUOp plus funct fields into the ALU control code.
module ex_stage_alu_control
  import ex_stage_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_control
);

  // Unlisted funct3 combinations fall back to ADD
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_MEM:    alu_control = ALU_ADD;
      ALUOP_BRANCH: alu_control = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct3)
          F3_ADDSUB: alu_control = funct7b5 ? ALU_SUB : ALU_ADD;
          F3_AND:    alu_control = ALU_AND;
          F3_OR:     alu_control = ALU_OR;
          default:   alu_control = ALU_ADD;
        endcase
      end
      ALUOP_ITYPE: begin
        case (funct3)
          F3_AND:  alu_control = ALU_AND;
          F3_OR:   alu_control = ALU_OR;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU drive, beq resolution, EX/MEM register.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_ex_valid,
  input  logic [XLEN-1:0]       id_ex_pc,
  input  logic [XLEN-1:0]       id_ex_rs1_data,
  input  logic [XLEN-1:0]       id_ex_rs2_data,
  input  logic [XLEN-1:0]       id_ex_imm,
  input  logic [REG_ADDR_W-1:0] id_ex_rs1,
  input  logic [REG_ADDR_W-1:0] id_ex_rs2,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic [1:0]            id_ex_alu_op,
  input  logic [2:0]            id_ex_funct3,
  input  logic                  id_ex_funct7b5,
  input  logic                  id_ex_alu_src,
  input  logic                  id_ex_branch,
  input  logic                  id_ex_mem_read,
  input  logic                  id_ex_mem_write,
  input  logic                  id_ex_reg_write,
  input  logic                  id_ex_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] fwd_mem_rd,
  input  logic                  fwd_mem_reg_write,
  input  logic [XLEN-1:0]       fwd_mem_data,
  input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
  input  logic                  fwd_wb_reg_write,
  input  logic [XLEN-1:0]       fwd_wb_data,
  output logic                  ex_mem_valid,
  output logic                  ex_mem_mem_read,
  output logic                  ex_mem_mem_write,
  output logic                  ex_mem_reg_write,
  output logic                  ex_mem_mem_to_reg,
  output logic [XLEN-1:0]       ex_mem_alu_result,
  output logic [XLEN-1:0]       ex_mem_store_data,
  output logic [REG_ADDR_W-1:0] ex_mem_rd,
  output logic                  ex_mem_overflow,
  output logic                  ex_mem_branch_taken,
  output logic [XLEN-1:0]       ex_mem_branch_target
);

  typedef struct packed {
    logic                  valid;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  overflow;
    logic                  branch_taken;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       store_data;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       branch_target;
  } ex_mem_t;

  // Operand index 0 is rs1, index 1 is rs2
  logic [REG_ADDR_W-1:0] rs_idx [2];
  logic [XLEN-1:0]       rs_reg [2];
  logic [XLEN-1:0]       rs_fwd [2];

  assign rs_idx[0] = id_ex_rs1;
  assign rs_idx[1] = id_ex_rs2;
  assign rs_reg[0] = id_ex_rs1_data;
  assign rs_reg[1] = id_ex_rs2_data;

  // x0 never forwards; the younger EX/MEM result wins over MEM/WB
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign rs_fwd[gi] =
        (fwd_mem_reg_write && (fwd_mem_rd == rs_idx[gi]) && (rs_idx[gi] != '0)) ? fwd_mem_data :
        (fwd_wb_reg_write  && (fwd_wb_rd  == rs_idx[gi]) && (rs_idx[gi] != '0)) ? fwd_wb_data  :
        rs_reg[gi];
    end
  endgenerate

  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            alu_overflow;

  assign alu_b = id_ex_alu_src ? id_ex_imm : rs_fwd[1];

  ex_stage_alu_control u_alu_control (
    .alu_op      (id_ex_alu_op),
    .funct3      (id_ex_funct3),
    .funct7b5    (id_ex_funct7b5),
    .alu_control (alu_ctrl)
  );

  alu #(.XLEN(XLEN)) u_alu (
    .a           (rs_fwd[0]),
    .b           (alu_b),
    .Alu_control (alu_ctrl),
    .result      (alu_result),
    .zero        (alu_zero),
    .overflow    (alu_overflow)
  );

  ex_mem_t ex_mem_q;
  ex_mem_t ex_mem_d;

  // Next EX/MEM contents: flush beats stall; invalid instructions load as bubbles
  always_comb begin
    ex_mem_d = ex_mem_q;
    if (!stall || flush) begin
      ex_mem_d.alu_result    = alu_result;
      ex_mem_d.store_data    = rs_fwd[1];
      ex_mem_d.rd            = id_ex_rd;
      ex_mem_d.branch_target = id_ex_pc + (id_ex_imm << 1);
      if (flush || !id_ex_valid) begin
        ex_mem_d.valid        = 1'b0;
        ex_mem_d.mem_read     = 1'b0;
        ex_mem_d.mem_write    = 1'b0;
        ex_mem_d.reg_write    = 1'b0;
        ex_mem_d.mem_to_reg   = 1'b0;
        ex_mem_d.overflow     = 1'b0;
        ex_mem_d.branch_taken = 1'b0;
      end else begin
        ex_mem_d.valid        = 1'b1;
        ex_mem_d.mem_read     = id_ex_mem_read;
        ex_mem_d.mem_write    = id_ex_mem_write;
        ex_mem_d.reg_write    = id_ex_reg_write;
        ex_mem_d.mem_to_reg   = id_ex_mem_to_reg;
        ex_mem_d.overflow     = alu_overflow;
        ex_mem_d.branch_taken = id_ex_branch & alu_zero;
      end
    end
  end

  // EX/MEM pipeline register with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_mem_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign ex_mem_valid         = ex_mem_q.valid;
  assign ex_mem_mem_read      = ex_mem_q.mem_read;
  assign ex_mem_mem_write     = ex_mem_q.mem_write;
  assign ex_mem_reg_write     = ex_mem_q.reg_write;
  assign ex_mem_mem_to_reg    = ex_mem_q.mem_to_reg;
  assign ex_mem_alu_result    = ex_mem_q.alu_result;
  assign ex_mem_store_data    = ex_mem_q.store_data;
  assign ex_mem_rd            = ex_mem_q.rd;
  assign ex_mem_overflow      = ex_mem_q.overflow;
  assign ex_mem_branch_taken  = ex_mem_q.branch_taken;
  assign ex_mem_branch_target = ex_mem_q.branch_target;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver queues expectations, monitor compares.
module tb_ex_stage;

  localparam int XLEN = 64;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            reset, stall, flush, id_ex_valid;
  logic [XLEN-1:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [RW-1:0]   id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [1:0]      id_ex_alu_op;
  logic [2:0]      id_ex_funct3;
  logic            id_ex_funct7b5, id_ex_alu_src, id_ex_branch;
  logic            id_ex_mem_read, id_ex_mem_write, id_ex_reg_write, id_ex_mem_to_reg;
  logic [RW-1:0]   fwd_mem_rd, fwd_wb_rd;
  logic            fwd_mem_reg_write, fwd_wb_reg_write;
  logic [XLEN-1:0] fwd_mem_data, fwd_wb_data;
  logic            ex_mem_valid, ex_mem_mem_read, ex_mem_mem_write, ex_mem_reg_write;
  logic            ex_mem_mem_to_reg, ex_mem_overflow, ex_mem_branch_taken;
  logic [XLEN-1:0] ex_mem_alu_result, ex_mem_store_data, ex_mem_branch_target;
  logic [RW-1:0]   ex_mem_rd;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc),
    .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
    .id_ex_imm(id_ex_imm), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_alu_op(id_ex_alu_op), .id_ex_funct3(id_ex_funct3),
    .id_ex_funct7b5(id_ex_funct7b5), .id_ex_alu_src(id_ex_alu_src),
    .id_ex_branch(id_ex_branch), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_mem_write(id_ex_mem_write), .id_ex_reg_write(id_ex_reg_write),
    .id_ex_mem_to_reg(id_ex_mem_to_reg),
    .fwd_mem_rd(fwd_mem_rd), .fwd_mem_reg_write(fwd_mem_reg_write),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_rd(fwd_wb_rd),
    .fwd_wb_reg_write(fwd_wb_reg_write), .fwd_wb_data(fwd_wb_data),
    .ex_mem_valid(ex_mem_valid), .ex_mem_mem_read(ex_mem_mem_read),
    .ex_mem_mem_write(ex_mem_mem_write), .ex_mem_reg_write(ex_mem_reg_write),
    .ex_mem_mem_to_reg(ex_mem_mem_to_reg), .ex_mem_alu_result(ex_mem_alu_result),
    .ex_mem_store_data(ex_mem_store_data), .ex_mem_rd(ex_mem_rd),
    .ex_mem_overflow(ex_mem_overflow), .ex_mem_branch_taken(ex_mem_branch_taken),
    .ex_mem_branch_target(ex_mem_branch_target)
  );

  typedef struct {
    string           name;
    logic            v, mr, mw, rw, mtr, ov, bt;
    logic [XLEN-1:0] res, sd, tgt;
    logic [RW-1:0]   rd;
    bit              chk_data;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  task automatic chk(input string txn, input string fld, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, want 0x%0h", txn, fld, act, want);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_txn++;
        chk(e.name, "valid",     ex_mem_valid,        e.v);
        chk(e.name, "mem_read",  ex_mem_mem_read,     e.mr);
        chk(e.name, "mem_write", ex_mem_mem_write,    e.mw);
        chk(e.name, "reg_write", ex_mem_reg_write,    e.rw);
        chk(e.name, "taken",     ex_mem_branch_taken, e.bt);
        if (e.chk_data) begin
          chk(e.name, "mem_to_reg", ex_mem_mem_to_reg,   e.mtr);
          chk(e.name, "overflow",   ex_mem_overflow,     e.ov);
          chk(e.name, "result",     ex_mem_alu_result,   e.res);
          chk(e.name, "store",      ex_mem_store_data,   e.sd);
          chk(e.name, "rd",         ex_mem_rd,           e.rd);
          chk(e.name, "target",     ex_mem_branch_target, e.tgt);
        end
        $display("txn %0d %s checked, failures so far %0d", n_txn, e.name, n_fail);
      end
    end
  end

  task automatic clr();
    reset = 0; stall = 0; flush = 0; id_ex_valid = 1;
    id_ex_pc = '0; id_ex_rs1_data = '0; id_ex_rs2_data = '0; id_ex_imm = '0;
    id_ex_rs1 = 5'd1; id_ex_rs2 = 5'd2; id_ex_rd = '0;
    id_ex_alu_op = 2'b10; id_ex_funct3 = 3'b000; id_ex_funct7b5 = 0;
    id_ex_alu_src = 0; id_ex_branch = 0; id_ex_mem_read = 0; id_ex_mem_write = 0;
    id_ex_reg_write = 0; id_ex_mem_to_reg = 0;
    fwd_mem_rd = '0; fwd_mem_reg_write = 0; fwd_mem_data = '0;
    fwd_wb_rd = '0; fwd_wb_reg_write = 0; fwd_wb_data = '0;
  endtask

  // Queue the expected EX/MEM contents for the coming edge, then advance
  task automatic issue(input string name, input logic v, mr, mw, rw, mtr, ov, bt,
                       input logic [XLEN-1:0] res, sd, input logic [RW-1:0] rd,
                       input logic [XLEN-1:0] tgt, input bit chk_data);
    exp_t e;
    e.name = name; e.v = v; e.mr = mr; e.mw = mw; e.rw = rw; e.mtr = mtr;
    e.ov = ov; e.bt = bt; e.res = res; e.sd = sd; e.rd = rd; e.tgt = tgt;
    e.chk_data = chk_data;
    exp_q.push_back(e);
    last_exp = e;
    @(negedge clk);
  endtask

  task automatic hold(input string name);
    exp_t e;
    e = last_exp;
    e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic set_add_10_20();
    clr();
    id_ex_rs1_data = 64'd10; id_ex_rs2_data = 64'd20; id_ex_rd = 5'd5; id_ex_reg_write = 1;
  endtask

  task automatic set_or();
    clr();
    id_ex_rs1_data = 64'hF000; id_ex_rs2_data = 64'h000F; id_ex_funct3 = 3'b110;
    id_ex_rd = 5'd10; id_ex_reg_write = 1;
  endtask

  initial begin
    int wait_cycles;
    clr(); reset = 1;
    issue("reset", 0,0,0,0,0,0,0, 64'd0, 64'd0, 5'd0, 64'd0, 1);

    set_add_10_20();
    issue("add", 1,0,0,1,0,0,0, 64'd30, 64'd20, 5'd5, 64'd0, 1);

    clr();
    id_ex_rs1 = 5'd3; id_ex_rs1_data = 64'd55; id_ex_rs2 = 5'd4; id_ex_rs2_data = 64'd1;
    fwd_mem_rd = 5'd3; fwd_mem_reg_write = 1; fwd_mem_data = 64'd100;
    fwd_wb_rd = 5'd3; fwd_wb_reg_write = 1; fwd_wb_data = 64'd7;
    id_ex_funct7b5 = 1; id_ex_rd = 5'd6; id_ex_reg_write = 1;
    issue("fwd_mem_prio", 1,0,0,1,0,0,0, 64'd99, 64'd1, 5'd6, 64'd0, 1);

    id_ex_rs1 = 5'd0; fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0;
    issue("fwd_x0", 1,0,0,1,0,0,0, 64'd54, 64'd1, 5'd6, 64'd0, 1);

    clr();
    id_ex_rs1_data = 64'd10; id_ex_rs2 = 5'd4; id_ex_rs2_data = 64'd99;
    fwd_mem_rd = 5'd9; fwd_mem_reg_write = 1; fwd_mem_data = 64'd100;
    fwd_wb_rd = 5'd4; fwd_wb_reg_write = 1; fwd_wb_data = 64'd7;
    id_ex_rd = 5'd8; id_ex_reg_write = 1;
    issue("fwd_wb", 1,0,0,1,0,0,0, 64'd17, 64'd7, 5'd8, 64'd0, 1);

    clr();
    id_ex_rs1 = 5'd3; id_ex_rs1_data = 64'd10; id_ex_rs2_data = 64'd5;
    fwd_mem_rd = 5'd3; fwd_mem_reg_write = 0; fwd_mem_data = 64'd100;
    fwd_wb_rd = 5'd3; fwd_wb_reg_write = 1; fwd_wb_data = 64'd7;
    id_ex_rd = 5'd8; id_ex_reg_write = 1;
    issue("fwd_mem_we0", 1,0,0,1,0,0,0, 64'd12, 64'd5, 5'd8, 64'd0, 1);

    clr();
    id_ex_pc = 64'h100; id_ex_imm = 64'd8; id_ex_rs1_data = 64'd50; id_ex_rs2_data = 64'd50;
    id_ex_alu_op = 2'b01; id_ex_branch = 1;
    issue("beq_taken", 1,0,0,0,0,0,1, 64'd0, 64'd50, 5'd0, 64'h110, 1);

    id_ex_rs2_data = 64'd49;
    issue("beq_not", 1,0,0,0,0,0,0, 64'd1, 64'd49, 5'd0, 64'h110, 1);

    id_ex_pc = 64'hFFFF_FFFF_FFFF_FFF0; id_ex_imm = 64'h10;
    id_ex_rs1_data = 64'd1; id_ex_rs2_data = 64'd1;
    issue("beq_wrap", 1,0,0,0,0,0,1, 64'd0, 64'd1, 5'd0, 64'h10, 1);

    clr();
    id_ex_rs1_data = 64'h7FFF_FFFF_FFFF_FFFF; id_ex_imm = 64'd1; id_ex_alu_src = 1;
    id_ex_alu_op = 2'b11; id_ex_rs2_data = 64'h33; id_ex_rd = 5'd7; id_ex_reg_write = 1;
    issue("addi_ovf", 1,0,0,1,0,1,0, 64'h8000_0000_0000_0000, 64'h33, 5'd7, 64'd2, 1);

    clr();
    id_ex_rs1_data = 64'hF0F0; id_ex_imm = 64'h0FF0; id_ex_alu_src = 1;
    id_ex_alu_op = 2'b11; id_ex_funct3 = 3'b111; id_ex_rd = 5'd9; id_ex_reg_write = 1;
    issue("andi", 1,0,0,1,0,0,0, 64'h00F0, 64'd0, 5'd9, 64'h1FE0, 1);

    set_or();
    issue("or", 1,0,0,1,0,0,0, 64'hF00F, 64'hF, 5'd10, 64'd0, 1);

    clr();
    id_ex_rs1_data = 64'd5; id_ex_rs2_data = 64'd6; id_ex_funct3 = 3'b001;
    id_ex_rd = 5'd11; id_ex_reg_write = 1;
    issue("default_add", 1,0,0,1,0,0,0, 64'd11, 64'd6, 5'd11, 64'd0, 1);

    clr();
    id_ex_rs1_data = 64'h8000_0000_0000_0000; id_ex_rs2_data = 64'd1; id_ex_funct7b5 = 1;
    id_ex_rd = 5'd12; id_ex_reg_write = 1;
    issue("sub_ovf", 1,0,0,1,0,1,0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd12, 64'd0, 1);

    clr();
    id_ex_rs1_data = 64'd100; id_ex_imm = 64'd8; id_ex_alu_src = 1; id_ex_alu_op = 2'b00;
    id_ex_mem_read = 1; id_ex_mem_to_reg = 1; id_ex_reg_write = 1; id_ex_rd = 5'd13;
    id_ex_rs2_data = 64'h44;
    issue("load", 1,1,0,1,1,0,0, 64'd108, 64'h44, 5'd13, 64'd16, 1);

    for (int i = 0; i < 3; i++) begin
      set_add_10_20(); stall = 1;
      hold("stall");
    end

    set_add_10_20(); stall = 1; flush = 1; id_ex_mem_write = 1; id_ex_branch = 1;
    issue("stall_flush", 0,0,0,0,0,0,0, 64'd0, 64'd0, 5'd0, 64'd0, 0);

    set_add_10_20(); id_ex_valid = 0;
    issue("bubble", 0,0,0,0,0,0,0, 64'd0, 64'd0, 5'd0, 64'd0, 0);

    clr();
    id_ex_rs1_data = 64'd200; id_ex_imm = 64'd16; id_ex_alu_src = 1; id_ex_alu_op = 2'b00;
    id_ex_mem_write = 1; id_ex_rs2_data = 64'hAB;
    issue("store", 1,0,1,0,0,0,0, 64'd216, 64'hAB, 5'd0, 64'd32, 1);

    set_add_10_20(); stall = 1; reset = 1;
    issue("reset_stall", 0,0,0,0,0,0,0, 64'd0, 64'd0, 5'd0, 64'd0, 1);

    set_or();
    issue("after_reset", 1,0,0,1,0,0,0, 64'hF00F, 64'hF, 5'd10, 64'd0, 1);

    clr(); id_ex_valid = 0;
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute-stage driver for the 64-bit ALU in the 5-stage RV64I pipeline. It consumes ID/EX pipeline state and selects forwarded operands. It decodes ALUOp/funct fields into the 4-bit ALU control code, drives the ALU's a/b/Alu_control, and consumes result/zero/overflow. Outputs are registered into the EX/MEM pipeline register, including beq branch resolution.

Parameters:
XLEN, 64, datapath width; must match ALU width.
REG_ADDR_W, 5, register index width.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; clears EX/MEM register
stall  input  1  hold EX/MEM contents (memory wait)
flush  input  1  load a bubble into EX/MEM
id_ex_valid  input  1  ID/EX holds a real instruction
id_ex_pc  input  XLEN  instruction PC
id_ex_rs1_data, id_ex_rs2_data  input  XLEN  register file read data
id_ex_imm  input  XLEN  sign-extended immediate
id_ex_rs1, id_ex_rs2, id_ex_rd  input  REG_ADDR_W  register indices
id_ex_alu_op  input  2  00 load/store add, 01 branch sub, 10 R-type, 11 I-type ALU
id_ex_funct3  input  3  instruction funct3
id_ex_funct7b5  input  1  instruction bit 30
id_ex_alu_src  input  1  1 selects immediate for ALU b
id_ex_branch, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write, id_ex_mem_to_reg  input  1 each  control bits
fwd_mem_rd  input  REG_ADDR_W  destination register of the EX/MEM instruction
fwd_mem_reg_write  input  1  write enable of the EX/MEM instruction
fwd_mem_data  input  XLEN  forwarded value from EX/MEM
fwd_wb_rd  input  REG_ADDR_W  destination register of the MEM/WB instruction
fwd_wb_reg_write  input  1  write enable of the MEM/WB instruction
fwd_wb_data  input  XLEN  forwarded value from MEM/WB
ex_mem_valid, ex_mem_mem_read, ex_mem_mem_write, ex_mem_reg_write, ex_mem_mem_to_reg  output  1 each  registered controls
ex_mem_alu_result  output  XLEN  registered ALU result
ex_mem_store_data  output  XLEN  registered forwarded rs2 value
ex_mem_rd  output  REG_ADDR_W  registered destination register
ex_mem_overflow  output  1  registered ALU overflow (status only, no trap)
ex_mem_branch_taken  output  1  registered beq taken
ex_mem_branch_target  output  XLEN  registered branch target

Behaviour:
- Reset: every ex_mem_* output is 0 on the first clk edge with reset=1. Priority: reset > flush > stall > normal load.
- Forwarding is combinational, per operand. EX/MEM source is used if fwd_mem_reg_write and fwd_mem_rd==rsN and rsN!=0. Otherwise MEM/WB source is used if fwd_wb_reg_write and fwd_wb_rd==rsN and rsN!=0. Otherwise register data is used. EX/MEM wins on a double match.
- ALU a = forwarded rs1. ALU b = id_ex_imm if alu_src, else forwarded rs2. ex_mem_store_data always takes forwarded rs2.
- Control decode (combinational), codes 0000 ADD, 0001 SUB, 0010 AND, 0011 OR:
  - alu_op 00 -> ADD; alu_op 01 -> SUB.
  - alu_op 10: funct3 000 gives SUB if funct7b5 else ADD; 111 gives AND; 110 gives OR.
  - alu_op 11: funct3 000 -> ADD; 111 -> AND; 110 -> OR.
  - Any other combination decodes to ADD, and the instruction is treated as valid.
- Latency: 1 cycle. Inputs valid at edge N appear on ex_mem_* after edge N.
- Branch: taken = id_ex_valid & id_ex_branch & zero. Target = id_ex_pc + (id_ex_imm << 1), modulo 2^XLEN wrap.
- Flush: ex_mem_valid, mem_read, mem_write, reg_write, branch_taken go to 0. Data fields are don't-care.
- Stall: all EX/MEM registers hold their values.
- id_ex_valid=0 is loaded as a bubble, identical to the flush result.
- Flush and stall in the same cycle: flush wins.
- Reset mid-stall: reset wins.

Decomposition:
- Shared package holds the ALU control codes (ADD/SUB/AND/OR) and the ALUOp encodings. The existing ALU uses the same package constants.
- Natural sub-module: alu_control (alu_op, funct3, funct7b5 -> Alu_control), purely combinational.
- The existing ALU is instantiated unchanged. The EX/MEM register and forwarding muxes stay in ex_stage.

Test Plan:
- R-type add: rs1=10, rs2=20, alu_op=10, funct3=000, funct7b5=0, rd=5, reg_write=1 -> next cycle alu_result=30, rd=5, reg_write=1, overflow=0.
- Forwarding priority: rs1=3 with fwd_mem_rd=3 (data 100) and fwd_wb_rd=3 (data 7), rs2 data 1, sub -> result=99. Repeat with rs1=0 -> register data is used.
- beq: pc=0x100, imm=8, operands 50/50, branch=1, alu_op=01 -> branch_taken=1, target=0x110. Operands 50/49 -> branch_taken=0.
- Overflow: a=0x7FFFFFFFFFFFFFFF, imm=1, alu_src=1, alu_op=11 addi -> result=0x8000000000000000, overflow=1, valid=1.
- Stall then flush: load an instruction, then stall=1 for 3 cycles -> outputs constant. Then stall=1 and flush=1 together -> valid, reg_write, mem_write and branch_taken all 0.
- Reset mid-operation: pipeline full, assert reset one cycle -> all ex_mem_* outputs 0 after that edge. Release reset -> normal loading resumes next cycle.
